// File: rtl/o_buf_pkg.sv
// rtl/o_buf_pkg.sv - state encoding and mode constants for the output-buffer controller
package o_buf_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OS_WR = 3'd1,
    ACC   = 3'd2,
    DRAIN = 3'd3,
    READ  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic MODE_OS = 1'b1;
  localparam logic MODE_WS = 1'b0;

endpackage

// File: rtl/o_buf_rd_seq.sv
// rtl/o_buf_rd_seq.sv - column-major readout walker with registered valid/last and backpressure
module o_buf_rd_seq #(
  parameter int ADDR_WIDTH = 8,
  parameter int ARRAY_M    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH-1:0]        num_rows,
  input  logic [$clog2(ARRAY_M):0]     num_cols,
  input  logic                         out_ready,
  output logic [$clog2(ARRAY_M)-1:0]   ram_idx,
  output logic [ADDR_WIDTH-1:0]        read_addr,
  output logic                         out_valid,
  output logic                         out_last
);

  logic [ADDR_WIDTH-1:0] row;
  logic                  issued;
  logic                  word_last;

  assign word_last = (row == num_rows - 1'b1) && ({1'b0, ram_idx} == num_cols - 1'b1);

  // read_addr/ram_idx always name the word in flight, so a stalled beat keeps the RAM output stable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row       <= '0;
      ram_idx   <= '0;
      read_addr <= '0;
      issued    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (start) begin
      row       <= '0;
      ram_idx   <= '0;
      read_addr <= base_addr;
      issued    <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (issued) begin
      issued    <= 1'b0;
      out_valid <= 1'b1;
      out_last  <= word_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (!word_last) begin
        issued <= 1'b1;
        if (row == num_rows - 1'b1) begin
          row       <= '0;
          ram_idx   <= ram_idx + 1'b1;
          read_addr <= base_addr;
        end else begin
          row       <= row + 1'b1;
          read_addr <= read_addr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/o_buffer_ctrl.sv
// rtl/o_buffer_ctrl.sv - tile sequencer for accumulator bank, column RAM writes and readout
module o_buffer_ctrl
  import o_buf_pkg::*;
#(
  parameter int RAM_SIZE   = 256,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int ARRAY_M    = 8,
  parameter int DEPTH      = 8,
  parameter int K_WIDTH    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_mode,
  input  logic [$clog2(ARRAY_M):0]     cmd_num_cols,
  input  logic [ADDR_WIDTH-1:0]        cmd_num_rows,
  input  logic [K_WIDTH-1:0]           cmd_k_len,
  input  logic [ADDR_WIDTH-1:0]        cmd_base_addr,
  input  logic                         in_valid,
  output logic                         idx_gen_on,
  output logic                         ag_o_on,
  output logic                         drain,
  output logic                         mode,
  output logic [$clog2(ARRAY_M):0]     num_cols,
  output logic [ADDR_WIDTH-1:0]        base_addr,
  output logic [$clog2(ARRAY_M)-1:0]   ram_idx,
  output logic [ADDR_WIDTH-1:0]        read_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         done
);

  localparam int COL_W = $clog2(ARRAY_M) + 1;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] rows, row_cnt;
  logic [K_WIDTH-1:0]    k_len, pass_cnt;
  logic                  row_last, cmd_empty, rd_start;

  assign row_last  = (row_cnt == rows - 1'b1);
  assign cmd_empty = (cmd_num_cols == '0) || (cmd_num_rows == '0) ||
                     ((cmd_mode == MODE_WS) && (cmd_k_len == '0));
  assign cmd_ready = (state == IDLE);
  assign drain     = (state == DRAIN);
  assign done      = (state == DONE);

  always_comb begin
    state_n    = state;
    ag_o_on    = 1'b0;
    idx_gen_on = 1'b0;
    rd_start   = 1'b0;
    case (state)
      IDLE: if (cmd_valid) state_n = cmd_empty ? DONE : ((cmd_mode == MODE_OS) ? OS_WR : ACC);
      OS_WR: begin
        ag_o_on = in_valid;
        if (in_valid && row_last) begin
          state_n  = READ;
          rd_start = 1'b1;
        end
      end
      ACC: begin
        idx_gen_on = in_valid;
        if (in_valid && row_last && (pass_cnt == k_len - 1'b1)) state_n = DRAIN;
      end
      DRAIN: begin
        ag_o_on = 1'b1;
        if (row_last) begin
          state_n  = READ;
          rd_start = 1'b1;
        end
      end
      READ: if (out_valid && out_ready && out_last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row_cnt   <= '0;
      pass_cnt  <= '0;
      rows      <= '0;
      k_len     <= '0;
      mode      <= 1'b0;
      num_cols  <= '0;
      base_addr <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (cmd_valid) begin
          mode      <= cmd_mode;
          num_cols  <= (cmd_num_cols > COL_W'(ARRAY_M)) ? COL_W'(ARRAY_M) : cmd_num_cols;
          base_addr <= cmd_base_addr;
          k_len     <= cmd_k_len;
          // the accumulator bank only holds DEPTH rows, so WS tiles are cut to that height
          rows      <= ((cmd_mode == MODE_WS) && (cmd_num_rows > ADDR_WIDTH'(DEPTH))) ?
                       ADDR_WIDTH'(DEPTH) : cmd_num_rows;
          row_cnt   <= '0;
          pass_cnt  <= '0;
        end
        OS_WR: if (in_valid) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        ACC: if (in_valid) begin
          if (row_last) begin
            row_cnt  <= '0;
            pass_cnt <= pass_cnt + 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        DRAIN: row_cnt <= row_last ? '0 : row_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  o_buf_rd_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ARRAY_M    (ARRAY_M)
  ) u_rd_seq (
    .clk       (clk),
    .reset     (reset),
    .start     (rd_start),
    .base_addr (base_addr),
    .num_rows  (rows),
    .num_cols  (num_cols),
    .out_ready (out_ready),
    .ram_idx   (ram_idx),
    .read_addr (read_addr),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_o_buffer_ctrl.sv
// tb/tb_o_buffer_ctrl.sv - self-checking bench for o_buffer_ctrl against a tile-level reference model
module tb_o_buffer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_mode;
  logic [3:0] cmd_num_cols;
  logic [7:0] cmd_num_rows, cmd_k_len, cmd_base_addr;
  logic       in_valid, idx_gen_on, ag_o_on, drain, mode;
  logic [3:0] num_cols;
  logic [7:0] base_addr, read_addr;
  logic [2:0] ram_idx;
  logic       out_valid, out_ready, out_last, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int c;
    int a;
    bit l;
  } word_t;
  word_t exp_q[$];

  logic [30:0] out_vec;
  localparam logic [30:0] RST_VEC = 31'h4000_0000;
  assign out_vec = {cmd_ready, idx_gen_on, ag_o_on, drain, mode, num_cols, base_addr,
                    ram_idx, read_addr, out_valid, out_last, done};

  always #5 clk = ~clk;

  o_buffer_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mode      (cmd_mode),
    .cmd_num_cols  (cmd_num_cols),
    .cmd_num_rows  (cmd_num_rows),
    .cmd_k_len     (cmd_k_len),
    .cmd_base_addr (cmd_base_addr),
    .in_valid      (in_valid),
    .idx_gen_on    (idx_gen_on),
    .ag_o_on       (ag_o_on),
    .drain         (drain),
    .mode          (mode),
    .num_cols      (num_cols),
    .base_addr     (base_addr),
    .ram_idx       (ram_idx),
    .read_addr     (read_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .done          (done)
  );

  // rdy: 0 always ready, 1 toggle 1010..., 2 random; abort_at>0 resets mid-READ at that cycle
  task automatic run_tile(input bit m, input int cols, input int rows, input int k,
                          input int base, input int rdy, input int abort_at, input string name);
    int eff_rows, eff_cols, beats, total, cyc, dseen, prev_c, prev_a;
    bit zero, seen_v, prev_acc, acc;
    word_t w;
    eff_cols = (cols > 8) ? 8 : cols;
    eff_rows = (m == 1'b0 && rows > 8) ? 8 : rows;
    zero = (cols == 0) || (rows == 0) || (m == 1'b0 && k == 0);
    cyc = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle: cmd_ready=%b required 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_mode = m; cmd_num_cols = 4'(cols); cmd_num_rows = 8'(rows);
    cmd_k_len = 8'(k); cmd_base_addr = 8'(base);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, mode, num_cols, base_addr} !== {1'b0, m, 4'(eff_cols), 8'(base)}) begin
      errors++;
      $display("FAIL %s latch: ready/mode/cols/base=%b/%b/%0d/%h required 0/%b/%0d/%h",
               name, cmd_ready, mode, num_cols, base_addr, m, eff_cols, 8'(base));
    end
    if (zero) begin
      dseen = 0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ag_o_on !== 1'b0 || idx_gen_on !== 1'b0) begin
          errors++;
          $display("FAIL %s zero_ctrl: ag_o_on=%b idx_gen_on=%b required 0", name, ag_o_on, idx_gen_on);
        end
        if (done === 1'b1) dseen++;
        @(negedge clk);
        #1;
      end
      checks++;
      if (dseen != 1 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s zero_done: done_pulses=%0d cmd_ready=%b required 1/1", name, dseen, cmd_ready);
      end
      return;
    end
    beats = 0; cyc = 0;
    total = (m == 1'b1) ? eff_rows : eff_rows * k;
    while (beats < total && cyc < 500) begin
      in_valid = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (m == 1'b1 && (ag_o_on !== in_valid || idx_gen_on !== 1'b0 || drain !== 1'b0)) begin
        errors++;
        $display("FAIL %s os_write: ag_o_on=%b idx_gen_on=%b drain=%b required %b/0/0",
                 name, ag_o_on, idx_gen_on, drain, in_valid);
      end
      if (m == 1'b0 && (idx_gen_on !== in_valid || ag_o_on !== 1'b0 || drain !== 1'b0)) begin
        errors++;
        $display("FAIL %s ws_acc: idx_gen_on=%b ag_o_on=%b drain=%b required %b/0/0",
                 name, idx_gen_on, ag_o_on, drain, in_valid);
      end
      if (in_valid) beats++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 500) begin
      errors++;
      $display("FAIL %s write_timeout: beats=%0d required %0d", name, beats, total);
    end
    if (m == 1'b0) begin
      for (int i = 0; i < eff_rows; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (drain !== 1'b1 || ag_o_on !== 1'b1 || idx_gen_on !== 1'b0) begin
          errors++;
          $display("FAIL %s drain[%0d]: drain=%b ag_o_on=%b idx_gen_on=%b required 1/1/0",
                   name, i, drain, ag_o_on, idx_gen_on);
        end
        @(negedge clk);
      end
    end
    exp_q.delete();
    for (int c = 0; c < eff_cols; c++)
      for (int r = 0; r < eff_rows; r++)
        exp_q.push_back('{c, (base + r) % 256, (c == eff_cols - 1) && (r == eff_rows - 1)});
    cyc = 0; seen_v = 1'b0; prev_acc = 1'b0; prev_c = 0; prev_a = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = (rdy == 0) ? 1'b1 : (rdy == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (abort_at != 0 && cyc == abort_at) begin
        #1 reset = 1'b1;
        #1;
        checks++;
        if (out_vec !== RST_VEC) begin
          errors++;
          $display("FAIL %s async_reset: outputs=%h required %h", name, out_vec, RST_VEC);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
          #1;
          checks++;
          if (done !== 1'b0 || cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after_reset: done=%b cmd_ready=%b out_valid=%b required 0/1/0",
                     name, done, cmd_ready, out_valid);
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        return;
      end
      checks++;
      if (ag_o_on !== 1'b0 || drain !== 1'b0 || idx_gen_on !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s read_ctrl: ag_o_on=%b drain=%b idx_gen_on=%b done=%b required 0",
                 name, ag_o_on, drain, idx_gen_on, done);
      end
      if (seen_v) begin
        checks++;
        if (!prev_acc && (int'(ram_idx) != prev_c || int'(read_addr) != prev_a)) begin
          errors++;
          $display("FAIL %s hold: idx/addr=%0d/%h required %0d/%h (no accept)",
                   name, ram_idx, read_addr, prev_c, prev_a);
        end
      end
      acc = (out_valid === 1'b1) && (out_ready === 1'b1);
      if (acc) begin
        w = exp_q.pop_front();
        checks++;
        if (ram_idx !== 3'(w.c) || read_addr !== 8'(w.a) || out_last !== w.l) begin
          errors++;
          $display("FAIL %s word: idx/addr/last=%0d/%h/%b required %0d/%h/%b",
                   name, ram_idx, read_addr, out_last, w.c, 8'(w.a), w.l);
        end
      end
      if (out_valid === 1'b1) seen_v = 1'b1;
      prev_acc = acc; prev_c = int'(ram_idx); prev_a = int'(read_addr);
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL %s read_timeout: words_left=%0d required 0", name, exp_q.size());
    end
    #1;
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done=%b cmd_ready=%b out_valid=%b required 1/0/0",
               name, done, cmd_ready, out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_return: done=%b cmd_ready=%b required 0/1", name, done, cmd_ready);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (out_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_values: outputs=%h required %h", out_vec, RST_VEC);
    end
    reset = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (out_vec !== RST_VEC) begin
      errors++;
      $display("FAIL idle_ignores_in_valid: outputs=%h required %h", out_vec, RST_VEC);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_os_basic;
    run_tile(1'b1, 8, 4, 0, 'h10, 0, 0, "os_basic");
  endtask

  task automatic test_ws_basic;
    run_tile(1'b0, 8, 4, 3, int'($urandom_range(0, 255)), 0, 0, "ws_basic");
  endtask

  task automatic test_backpressure;
    run_tile(1'b1, 8, 4, 0, 'h20, 1, 0, "backpressure");
    run_tile(1'b0, 3, 5, 2, 'h30, 2, 0, "backpressure_rand");
  endtask

  task automatic test_wrap;
    run_tile(1'b1, 1, 4, 0, 'hFE, 2, 0, "wrap");
  endtask

  task automatic test_zero_clamp;
    run_tile(1'b1, 0, 4, 0, 'h00, 0, 0, "zero_cols");
    run_tile(1'b0, 3, 4, 0, 'h08, 0, 0, "zero_k");
    run_tile(1'b1, 2, 0, 0, 'h08, 0, 0, "zero_rows");
    run_tile(1'b1, 9, 2, 0, 'h05, 0, 0, "clamp9");
    run_tile(1'b0, 2, 10, 1, 'h60, 0, 0, "ws_truncate");
  endtask

  task automatic test_reset_mid_read;
    run_tile(1'b1, 4, 4, 0, 'h40, 2, 7, "reset_mid_read");
    run_tile(1'b1, 2, 3, 0, 'h50, 0, 0, "after_reset");
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++)
      run_tile(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)), int'($urandom_range(0, 6)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 2)), 0, "random");
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_num_cols = '0; cmd_num_rows = '0;
    cmd_k_len = '0; cmd_base_addr = '0; in_valid = 1'b0; out_ready = 1'b1;
    test_reset;
    test_os_basic;
    test_ws_basic;
    test_backpressure;
    test_wrap;
    test_zero_clamp;
    test_reset_mid_read;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
